wb_sequencer: RTL and testbench
===============================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 SHALL: Clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: Clr_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: in_valid  input  1  a write-back operation is offered this cycle.
REQ-004 SHALL: in_ready  output  1  the sequencer accepts the offered operation this cycle.
REQ-005 SHALL: in_rd  input  5  destination register number.
REQ-006 SHALL: in_double  input  1  1 means a doubleword (LDD-style) write to an even/odd register pair.
REQ-007 SHALL: in_data_hi  input  32  most-significant word; the only word used for single writes.
REQ-008 SHALL: in_data_lo  input  32  least-significant word; used only when in_double=1.
REQ-009 SHALL: PW  output  32  write data to the register-file write port.
REQ-010 SHALL: RW  output  5  write register number to the register-file write port.
REQ-011 SHALL: LE  output  1  register-file load enable.
REQ-012 SHALL: busy  output  1  high while any write is being presented (state != S_IDLE).

Function
REQ-013 SHALL: FSM states S_IDLE, S_W1 (presenting first or only word), S_W2 (presenting second word of a double).
REQ-014 SHALL: accept = in_valid & in_ready; an operation transfers only on a rising edge where accept=1.
REQ-015 SHALL: in_ready = 0 only in S_W1 while the captured operation is a double; 1 in every other state.
REQ-016 SHALL: in_ready depends combinationally on state only, never on in_valid.
REQ-017 SHALL: on accept, next state = S_W1; captured rd, double flag and both data words are registered.
REQ-018 SHALL: in S_W1: LE=1, PW=captured hi; RW=captured rd for a single, {rd[4:1],0} for a double.
REQ-019 SHALL: in S_W1 with a double, next state = S_W2 unconditionally.
REQ-020 SHALL: in S_W2: LE=1, RW={rd[4:1],1}, PW=captured lo.
REQ-021 SHALL: in S_W1 (single) or S_W2, next state = S_W1 on accept, otherwise S_IDLE.
REQ-022 SHALL: in S_IDLE: LE=0; PW and RW hold their last values.
REQ-023 SHALL: latency -- an operation accepted at edge k drives LE=1 during cycle k..k+1, so the register file loads at edge k+1; a double's second word loads at edge k+2.
REQ-024 SHALL: back-to-back singles sustain one write per cycle with no bubble.
REQ-025 SHALL: a double followed by any operation inserts no bubble; the follower is accepted in S_W2.
REQ-026 SHALL: a double with odd in_rd ignores rd[0] (pair is aligned down).
REQ-027 SHALL: PW, RW and LE are driven directly from flops (no combinational path from inputs).

Reset
REQ-028 SHALL: while Clr_n=0: state=S_IDLE, LE=0, busy=0, PW=0, RW=0, captured fields=0, in_ready=1.
REQ-029 SHALL: reset asserted during S_W1 or S_W2 aborts the operation immediately; a pending second word is discarded and never written.
REQ-030 SHALL: the first accept occurs no earlier than the first rising edge after Clr_n deasserts.

Configuration
REQ-031 SHALL: macro WB_G0_DISCARD_EN defined -- in any write cycle where RW=0, LE is forced to 0; FSM sequencing and timing are unchanged (a double to r0/r1 still writes r1).
REQ-032 SHALL: macro WB_G0_DISCARD_EN undefined -- writes to register 0 are presented with LE=1 like any other register.

Verification
REQ-033 SHALL: single rd=5, hi=0xDEADBEEF, accepted at edge 1 -> cycle after edge 1: LE=1, RW=5, PW=0xDEADBEEF; after edge 2: LE=0, busy=0.
REQ-034 SHALL: double rd=9, hi=0x11111111, lo=0x22222222 -> RW=8/PW=0x11111111, then RW=9/PW=0x22222222; in_ready=0 only during the first write cycle.
REQ-035 SHALL: in_valid held high for singles rd=1,2,3 on consecutive cycles -> LE=1 for three consecutive cycles, RW=1,2,3, in_ready constant 1.
REQ-036 SHALL: Clr_n pulsed low mid-cycle during the first word of double rd=4 -> LE falls asynchronously, RW=0, register 5 never written, in_ready=1.
REQ-037 SHALL: single rd=0, hi=0xFFFFFFFF -> LE=0 for that cycle with WB_G0_DISCARD_EN defined; LE=1, RW=0 without it.
REQ-038 SHALL: double rd=6 followed immediately by single rd=7 held valid -> writes RW=6, 6|1=7 (lo), then RW=7 (hi of second op) on three consecutive cycles, no gap.

Source files
------------

// File: rtl/wb_sequencer.sv
// wb_sequencer -- write-back sequencer; splits doubleword writes into two register-file writes. Rev 1.0
// Optional feature: define WB_G0_DISCARD_EN to suppress LE on any write whose RW is 0.
`default_nettype none

module wb_sequencer (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_double,
  input  logic [31:0] in_data_hi,
  input  logic [31:0] in_data_lo,
  output logic [31:0] PW,
  output logic [4:0]  RW,
  output logic        LE,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_W1   = 2'd1,
    S_W2   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_pair;
  logic        r_dbl;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_second;
  logic        w_upd;
  logic        w_le_nxt;
  logic [4:0]  w_rw_nxt;
  logic [31:0] w_pw_nxt;

  assign in_ready = !((r_state == S_W1) && r_dbl);
  assign busy     = (r_state != S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_second = (r_state == S_W1) && r_dbl;

  // Output flops are loaded with the values for the coming cycle, so an
  // accept at edge k presents its first word during cycle k..k+1.
  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_rw_nxt    = RW;
    w_pw_nxt    = PW;
    if (w_second) begin
      w_state_nxt = S_W2;
      w_upd       = 1'b1;
      w_rw_nxt    = {r_pair, 1'b1};
      w_pw_nxt    = r_lo;
    end else if (w_accept) begin
      w_state_nxt = S_W1;
      w_upd       = 1'b1;
      w_rw_nxt    = in_double ? {in_rd[4:1], 1'b0} : in_rd;
      w_pw_nxt    = in_data_hi;
    end else begin
      w_state_nxt = S_IDLE;
    end
  end

`ifdef WB_G0_DISCARD_EN
  assign w_le_nxt = w_upd && (w_rw_nxt != 5'd0);
`else
  assign w_le_nxt = w_upd;
`endif

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_state <= S_IDLE;
      PW      <= 32'd0;
      RW      <= 5'd0;
      LE      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      PW      <= w_pw_nxt;
      RW      <= w_rw_nxt;
      LE      <= w_le_nxt;
    end
  end

  // Captured operation; only the pair index and low word are needed later,
  // the high word goes straight into PW.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_pair <= 4'd0;
      r_dbl  <= 1'b0;
      r_lo   <= 32'd0;
    end else if (w_accept) begin
      r_pair <= in_rd[4:1];
      r_dbl  <= in_double;
      r_lo   <= in_data_lo;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer -- directed self-checking bench for wb_sequencer.
`default_nettype none

module tb_wb_sequencer;

  logic        Clk;
  logic        Clr_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_double;
  logic [31:0] in_data_hi;
  logic [31:0] in_data_lo;
  logic [31:0] PW;
  logic [4:0]  RW;
  logic        LE;
  logic        busy;

  int n_total;
  int n_bad;

  wb_sequencer u_dut (
    .Clk        (Clk),
    .Clr_n      (Clr_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_double  (in_double),
    .in_data_hi (in_data_hi),
    .in_data_lo (in_data_lo),
    .PW         (PW),
    .RW         (RW),
    .LE         (LE),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef WB_G0_DISCARD_EN
  localparam logic c_LE_R0 = 1'b0;
`else
  localparam logic c_LE_R0 = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic dbl, input logic [31:0] hi, input logic [31:0] lo);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_double  = dbl;
    in_data_hi = hi;
    in_data_lo = lo;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    Clr_n      = 1'b0;
    in_valid   = 1'b0;
    in_rd      = 5'd0;
    in_double  = 1'b0;
    in_data_hi = 32'd0;
    in_data_lo = 32'd0;

    #3;
    chk("rst_le",    {31'd0, LE},       32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_pw",    PW,                32'd0);
    chk("rst_rw",    {27'd0, RW},       32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    #9 Clr_n = 1'b1;
    tick();

    // single rd=5
    offer(5'd5, 1'b0, 32'hDEADBEEF, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("s5_le",   {31'd0, LE},       32'd1);
    chk("s5_rw",   {27'd0, RW},       32'd5);
    chk("s5_pw",   PW,                32'hDEADBEEF);
    chk("s5_busy", {31'd0, busy},     32'd1);
    chk("s5_rdy",  {31'd0, in_ready}, 32'd1);
    tick();
    chk("s5_le_off",   {31'd0, LE},   32'd0);
    chk("s5_busy_off", {31'd0, busy}, 32'd0);
    chk("s5_pw_hold",  PW,            32'hDEADBEEF);

    // double rd=9
    offer(5'd9, 1'b1, 32'h11111111, 32'h22222222);
    tick();
    in_valid = 1'b0;
    chk("d9_w1_rw",  {27'd0, RW},       32'd8);
    chk("d9_w1_pw",  PW,                32'h11111111);
    chk("d9_w1_le",  {31'd0, LE},       32'd1);
    chk("d9_w1_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("d9_w2_rw",  {27'd0, RW},       32'd9);
    chk("d9_w2_pw",  PW,                32'h22222222);
    chk("d9_w2_le",  {31'd0, LE},       32'd1);
    chk("d9_w2_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    chk("d9_done_le", {31'd0, LE}, 32'd0);

    // back-to-back singles rd=1,2,3
    for (int i = 1; i <= 3; i++) begin
      offer(5'(i), 1'b0, 32'hA0000000 + 32'(i), 32'h0);
      tick();
      chk("b2b_le",  {31'd0, LE},       32'd1);
      chk("b2b_rw",  {27'd0, RW},       32'(i));
      chk("b2b_pw",  PW,                32'hA0000000 + 32'(i));
      chk("b2b_rdy", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_le_off", {31'd0, LE}, 32'd0);

    // double rd=6 followed by single rd=7 held valid
    offer(5'd6, 1'b1, 32'h66660000, 32'h00006666);
    tick();
    offer(5'd7, 1'b0, 32'h77777777, 32'h0);
    chk("d6_w1_rw",  {27'd0, RW},       32'd6);
    chk("d6_w1_pw",  PW,                32'h66660000);
    chk("d6_w1_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("d6_w2_rw",  {27'd0, RW},       32'd7);
    chk("d6_w2_pw",  PW,                32'h00006666);
    chk("d6_w2_le",  {31'd0, LE},       32'd1);
    tick();
    in_valid = 1'b0;
    chk("s7_rw", {27'd0, RW}, 32'd7);
    chk("s7_pw", PW,          32'h77777777);
    chk("s7_le", {31'd0, LE}, 32'd1);
    tick();
    chk("s7_le_off", {31'd0, LE}, 32'd0);

    // reset in the first word of double rd=4
    offer(5'd4, 1'b1, 32'h44440000, 32'h00004444);
    tick();
    in_valid = 1'b0;
    chk("d4_w1_rw", {27'd0, RW}, 32'd4);
    chk("d4_w1_le", {31'd0, LE}, 32'd1);
    #2 Clr_n = 1'b0;
    #1;
    chk("d4_rst_le",   {31'd0, LE},       32'd0);
    chk("d4_rst_rw",   {27'd0, RW},       32'd0);
    chk("d4_rst_pw",   PW,                32'd0);
    chk("d4_rst_busy", {31'd0, busy},     32'd0);
    chk("d4_rst_rdy",  {31'd0, in_ready}, 32'd1);
    #1 Clr_n = 1'b1;
    tick();
    chk("d4_no_w2_le", {31'd0, LE}, 32'd0);
    chk("d4_no_w2_rw", {27'd0, RW}, 32'd0);

    // single to r0
    offer(5'd0, 1'b0, 32'hFFFFFFFF, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("r0_le", {31'd0, LE}, {31'd0, c_LE_R0});
    chk("r0_rw", {27'd0, RW}, 32'd0);
    chk("r0_pw", PW,          32'hFFFFFFFF);
    tick();

    // double to r0/r1: r1 is always written
    offer(5'd1, 1'b1, 32'h01010101, 32'h02020202);
    tick();
    in_valid = 1'b0;
    chk("d0_w1_le", {31'd0, LE}, {31'd0, c_LE_R0});
    chk("d0_w1_rw", {27'd0, RW}, 32'd0);
    tick();
    chk("d0_w2_le", {31'd0, LE}, 32'd1);
    chk("d0_w2_rw", {27'd0, RW}, 32'd1);
    chk("d0_w2_pw", PW,          32'h02020202);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
